// File: rtl/lsu.sv
// Load/store unit: accepts an effective address and memory op from the core,
// drives a valid/ready data-memory port and returns a one-cycle response.
module lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [DW-1:0]   req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            req_err;
  logic [1:0]      off;
  logic [DW/8-1:0] lane_strb;
  logic [DW-1:0]   lane_wdata;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [DW-1:0]   load_ext;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wen_d    = req_wen;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          err_d    = req_err;
          rdata_d  = '0;
          state_d  = req_err ? RESP : REQ;
        end
      end
      REQ: begin
        // Read data may arrive in the handshake cycle itself, skipping WAIT.
        if (mem_ready) begin
          if (wen_q) begin
            state_d = RESP;
          end else if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign off = addr_q[1:0];

  always_comb begin
    lane_strb  = '0;
    lane_wdata = '0;
    case (size_q)
      2'd0: begin
        lane_strb  = 4'b0001 << off;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_strb  = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'(rdata_q >> {off, 3'b000});
    half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    case (size_q)
      2'd0:    load_ext = {{(DW-8){signed_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{(DW-16){signed_q & half_sel[15]}}, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_valid  = (state_q == REQ);
  assign mem_addr   = mem_valid ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_wen    = mem_valid & wen_q;
  assign mem_wstrb  = mem_wen ? lane_strb : '0;
  assign mem_wdata  = mem_wen ? lane_wdata : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !wen_q) ? load_ext : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written reset and
// spurious-rvalid sequences, then random requests against a reference model.
module tb_lsu;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [DW-1:0] req_wdata;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;

  always #5 clk = ~clk;

  lsu #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] memWord;
    int          rdy;
    int          rv;
    logic        expErr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    logic [31:0] expAddr;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  string curTag   = "init";
  vec_t  vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s/%s: got 0x%08h expected 0x%08h", curTag, name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(logic [31:0] addr, logic wen, logic [1:0] size, logic sgn,
                                 logic [31:0] wdata, logic [31:0] memWord, int rdy, int rv,
                                 logic expErr, logic [3:0] expStrb, logic [31:0] expWdata,
                                 logic [31:0] expRdata, logic [31:0] expAddr);
    vec_t v;
    v.addr = addr; v.wen = wen; v.size = size; v.sgn = sgn; v.wdata = wdata;
    v.memWord = memWord; v.rdy = rdy; v.rv = rv; v.expErr = expErr;
    v.expStrb = expStrb; v.expWdata = expWdata; v.expRdata = expRdata; v.expAddr = expAddr;
    return v;
  endfunction

  // Reference model: expectations from the access rules using plain arithmetic.
  function automatic vec_t modelVec(logic [31:0] addr, logic wen, logic [1:0] size, logic sgn,
                                    logic [31:0] wdata, logic [31:0] memWord, int rdy, int rv);
    int unsigned off;
    logic [31:0] v;
    vec_t r;
    off = addr % 4;
    r = mkVec(addr, wen, size, sgn, wdata, memWord, rdy, rv, 1'b0, 4'd0, 32'd0, 32'd0,
              addr - off);
    r.expErr = (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    if (size == 0) begin
      r.expStrb  = 4'(1 << off);
      r.expWdata = (wdata % 256) * 32'h0101_0101;
      v = (memWord >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      r.expStrb  = 4'(3 << off);
      r.expWdata = (wdata % 65536) * 32'h0001_0001;
      v = (memWord >> (8 * off)) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      r.expStrb  = 4'hF;
      r.expWdata = wdata;
      v = memWord;
    end
    if (!wen) begin
      r.expStrb  = 4'd0;
      r.expRdata = v;
    end
    if (r.expErr) r.expRdata = 32'd0;
    return r;
  endfunction

  // Drives one request and plays the memory side with the vector's delays.
  task automatic applyStimulus(input vec_t v);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_wen = v.wen; req_size = v.size;
    req_signed = v.sgn; req_wdata = v.wdata;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wen = 1'($urandom);
    req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = $urandom;
    if (v.expErr) begin
      checkOutput("err_mem_valid", {31'd0, mem_valid}, 32'd0);
      checkOutput("err_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("err_resp_err", {31'd0, resp_err}, 32'd1);
      checkOutput("err_resp_rdata", resp_rdata, 32'd0);
      tick();
      checkOutput("err_resp_drop", {31'd0, resp_valid}, 32'd0);
      checkOutput("err_req_ready", {31'd0, req_ready}, 32'd1);
      return;
    end
    for (int k = 0; k <= v.rdy; k++) begin
      checkOutput("mem_valid", {31'd0, mem_valid}, 32'd1);
      checkOutput("mem_addr", mem_addr, v.expAddr);
      checkOutput("mem_wen", {31'd0, mem_wen}, {31'd0, v.wen});
      checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.expStrb});
      if (v.wen) checkOutput("mem_wdata", mem_wdata, v.expWdata);
      checkOutput("req_resp_valid", {31'd0, resp_valid}, 32'd0);
      mem_ready = (k == v.rdy);
      if (k == v.rdy && !v.wen && v.rv == 0) begin
        mem_rvalid = 1'b1; mem_rdata = v.memWord;
      end else if (k < v.rdy) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      end
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b0;
    end
    if (!v.wen && v.rv > 0) begin
      for (int j = 1; j <= v.rv; j++) begin
        checkOutput("wait_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("wait_busy", {31'd0, busy}, 32'd1);
        checkOutput("wait_resp_valid", {31'd0, resp_valid}, 32'd0);
        if (j == v.rv) begin
          mem_rvalid = 1'b1; mem_rdata = v.memWord;
        end
        tick();
        mem_rvalid = 1'b0;
      end
    end
    checkOutput("resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("resp_rdata", resp_rdata, v.expRdata);
    checkOutput("resp_mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("resp_req_ready", {31'd0, req_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    checkOutput("resp_rdata_idle", resp_rdata, 32'd0);
    checkOutput("back_to_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Directed table: hand-computed expectations.
    vecs.push_back(mkVec(32'h8000_0004, 0, 2, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 4'h0, 0, 32'hDEAD_BEEF, 32'h8000_0004));
    vecs.push_back(mkVec(32'h8000_0003, 0, 0, 1, 0, 32'h80FF_1234, 0, 0, 0, 4'h0, 0, 32'hFFFF_FF80, 32'h8000_0000));
    vecs.push_back(mkVec(32'h8000_0003, 0, 0, 0, 0, 32'h80FF_1234, 0, 0, 0, 4'h0, 0, 32'h0000_0080, 32'h8000_0000));
    vecs.push_back(mkVec(32'h8000_0002, 1, 1, 0, 32'h0000_ABCD, 0, 3, 0, 0, 4'hC, 32'hABCD_ABCD, 0, 32'h8000_0000));
    vecs.push_back(mkVec(32'h8000_0001, 0, 2, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mkVec(32'h8000_0003, 0, 1, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mkVec(32'h8000_0000, 1, 3, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mkVec(32'h8000_0000, 0, 1, 1, 0, 32'h0000_7FFF, 0, 5, 0, 4'h0, 0, 32'h0000_7FFF, 32'h8000_0000));
    vecs.push_back(mkVec(32'h8000_0001, 1, 0, 0, 32'h1234_56A5, 0, 1, 0, 0, 4'h2, 32'hA5A5_A5A5, 0, 32'h8000_0000));
    vecs.push_back(mkVec(32'h8000_0006, 0, 1, 1, 0, 32'h8001_0000, 2, 1, 0, 4'h0, 0, 32'hFFFF_8001, 32'h8000_0004));
    vecs.push_back(mkVec(32'h8000_0008, 1, 2, 0, 32'h0123_4567, 0, 0, 0, 0, 4'hF, 32'h0123_4567, 0, 32'h8000_0008));
    vecs.push_back(mkVec(32'h8000_000E, 0, 1, 0, 0, 32'hF00D_1234, 0, 0, 0, 4'h0, 0, 32'h0000_F00D, 32'h8000_000C));
    vecs.push_back(mkVec(32'h8000_0010, 0, 2, 1, 0, 32'h8000_0000, 1, 2, 0, 4'h0, 0, 32'h8000_0000, 32'h8000_0010));

    tick();
    curTag = "reset";
    checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("busy", {31'd0, busy}, 32'd0);
    checkOutput("mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("mem_addr", mem_addr, 32'd0);
    checkOutput("mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      curTag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i]);
    end

    // Spurious rvalid while idle must not start or complete anything.
    curTag = "spurious";
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("busy", {31'd0, busy}, 32'd0);
    checkOutput("resp_valid", {31'd0, resp_valid}, 32'd0);
    applyStimulus(vecs[7]);

    // Reset asserted while waiting for read data.
    curTag = "rst_wait";
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    tick();
    req_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("busy_before", {31'd0, busy}, 32'd1);
    checkOutput("mem_valid_wait", {31'd0, mem_valid}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("busy", {31'd0, busy}, 32'd0);
    checkOutput("mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("late_rvalid_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("late_rvalid_resp2", {31'd0, resp_valid}, 32'd0);
    curTag = "after_rst";
    applyStimulus(vecs[0]);

    // Random requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      vec_t r;
      r = modelVec(32'h8000_0000 | ($urandom & 32'h0000_0FFF), 1'($urandom), 2'($urandom_range(0, 3)),
                   1'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      curTag = $sformatf("rand%0d", n);
      applyStimulus(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
